// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MUL_WAIT = 1'b1
   } state_t;

   localparam int unsigned REG_W_DEFAULT   = 5;
   localparam int unsigned ZERO_REG        = 0;
   localparam int unsigned MUL_LATENCY_MIN = 3;

   // Latencies below the minimum would make the countdown load value negative.
   function automatic int unsigned mul_latency_eff(input int unsigned lat);
      return (lat < MUL_LATENCY_MIN) ? MUL_LATENCY_MIN : lat;
   endfunction

endpackage

// File: rtl/mul_stall_timer.sv
// Multiply occupancy countdown: loaded on multiply entry, decrements while busy.
module mul_stall_timer
   import hazard_pkg::*;
#(
   parameter int unsigned MUL_LATENCY = 4
) (
   input  logic Clk,
   input  logic Reset,
   input  logic load,
   output logic busy,
   output logic last
);

   localparam int unsigned LAT   = mul_latency_eff(MUL_LATENCY);
   localparam int unsigned CNT_W = $clog2(LAT);

   logic [CNT_W-1:0] cnt;

   // The first hold cycle is spent in RUN, so only LAT-2 wait cycles remain.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CNT_W'(LAT - 2);
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign busy = (cnt != '0);
   assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard detection and stall/flush control for the 5-stage pipeline.
// Optional stall counter enabled by HAZARD_STALL_CNT_EN.
module hazard_stall_unit
   import hazard_pkg::*;
#(
   parameter int unsigned MUL_LATENCY = 4,
   parameter int unsigned REG_W       = REG_W_DEFAULT
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [REG_W-1:0] IDRs,
   input  logic [REG_W-1:0] IDRt,
   input  logic             IDUsesRt,
   input  logic             IDBranch,
   input  logic             IDBranchTaken,
   input  logic             EXMemRead,
   input  logic             EXRegWrite,
   input  logic [REG_W-1:0] EXWriteReg,
   input  logic             MEMMemRead,
   input  logic [REG_W-1:0] MEMWriteReg,
   input  logic             EXMulStart,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IDEXFlush,
   output logic             IFIDFlush,
   output logic             EXHold,
   output logic [31:0]      StallCount
);

   localparam logic [REG_W-1:0] ZERO = REG_W'(ZERO_REG);

   state_t state;
   state_t state_next;
   logic   load_use;
   logic   br_dep;
   logic   ex_hit;
   logic   mem_hit;
   logic   mul_load;
   logic   mul_busy;
   logic   mul_last;

   // Combinational hazard detection; register 0 never hazards.
   always_comb begin
      load_use = EXMemRead && (EXWriteReg != ZERO) &&
                 ((EXWriteReg == IDRs) || (IDUsesRt && (EXWriteReg == IDRt)));
      ex_hit   = EXRegWrite && (EXWriteReg != ZERO) &&
                 ((EXWriteReg == IDRs) || (EXWriteReg == IDRt));
      mem_hit  = MEMMemRead && (MEMWriteReg != ZERO) &&
                 ((MEMWriteReg == IDRs) || (MEMWriteReg == IDRt));
      br_dep   = IDBranch && (ex_hit || mem_hit);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      mul_load   = 1'b0;
      case (state)
         RUN: begin
            if (EXMulStart) begin
               state_next = MUL_WAIT;
               mul_load   = 1'b1;
            end
         end
         MUL_WAIT: begin
            if (mul_last || !mul_busy) begin
               state_next = RUN;
            end
         end
         default: state_next = RUN;
      endcase
   end

   // A multiply in EX outranks ID hazards; those are re-evaluated after the wait.
   always_comb begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXFlush = 1'b0;
      IFIDFlush = 1'b0;
      EXHold    = 1'b0;
      if (Reset) begin
         case (state)
            RUN: begin
               if (EXMulStart) begin
                  PCWrite   = 1'b1;
                  IFIDWrite = 1'b1;
                  EXHold    = 1'b1;
               end else if (load_use || br_dep) begin
                  PCWrite   = 1'b1;
                  IFIDWrite = 1'b1;
                  IDEXFlush = 1'b1;
               end else begin
                  IFIDFlush = IDBranch && IDBranchTaken;
               end
            end
            MUL_WAIT: begin
               PCWrite   = 1'b1;
               IFIDWrite = 1'b1;
               EXHold    = 1'b1;
            end
            default: begin
               PCWrite = 1'b0;
            end
         endcase
      end
   end

   mul_stall_timer #(
      .MUL_LATENCY (MUL_LATENCY)
   ) u_mul_stall_timer (
      .Clk   (Clk),
      .Reset (Reset),
      .load  (mul_load),
      .busy  (mul_busy),
      .last  (mul_last)
   );

`ifdef HAZARD_STALL_CNT_EN
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         StallCount <= '0;
      end else if (PCWrite) begin
         StallCount <= StallCount + 32'd1;
      end
   end
`else
   assign StallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench: directed vector table, multi-cycle sequences, random vs. reference model.
module tb_hazard_stall_unit;

   localparam int unsigned REG_W = 5;
   localparam int unsigned LAT   = 4;

   logic             Clk;
   logic             Reset;
   logic [REG_W-1:0] IDRs, IDRt, EXWriteReg, MEMWriteReg;
   logic             IDUsesRt, IDBranch, IDBranchTaken;
   logic             EXMemRead, EXRegWrite, MEMMemRead, EXMulStart;
   logic             PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, EXHold;
   logic [31:0]      StallCount;

   hazard_stall_unit #(.MUL_LATENCY(LAT), .REG_W(REG_W)) dut (
      .Clk(Clk), .Reset(Reset), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
      .IDBranch(IDBranch), .IDBranchTaken(IDBranchTaken), .EXMemRead(EXMemRead),
      .EXRegWrite(EXRegWrite), .EXWriteReg(EXWriteReg), .MEMMemRead(MEMMemRead),
      .MEMWriteReg(MEMWriteReg), .EXMulStart(EXMulStart), .PCWrite(PCWrite),
      .IFIDWrite(IFIDWrite), .IDEXFlush(IDEXFlush), .IFIDFlush(IFIDFlush),
      .EXHold(EXHold), .StallCount(StallCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [4:0] rs, rt;
      logic       uses_rt, br, taken, ex_mr, ex_rw;
      logic [4:0] ex_wr;
      logic       mem_mr;
      logic [4:0] mem_wr;
      logic       mul;
      logic [4:0] exp;   // {PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, EXHold}
   } vec_t;

   localparam logic [4:0] O_NONE = 5'b00000;
   localparam logic [4:0] O_BUB  = 5'b11100;
   localparam logic [4:0] O_FL   = 5'b00010;
   localparam logic [4:0] O_MUL  = 5'b11001;

   int checks = 0;
   int passes = 0;
   int rem    = 0;        // remaining MUL_WAIT cycles in the model
   logic [31:0] exp_cnt = '0;

   function automatic logic [4:0] outs();
      return {PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, EXHold};
   endfunction

   task automatic check_outs(input string name, input logic [4:0] exp);
      logic [4:0] got;
      got = outs();
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: outputs got %b required %b", name, got, exp);
   endtask

   task automatic check_cnt(input string name, input logic [31:0] exp);
      checks++;
      if (StallCount === exp) passes++;
      else $display("FAIL %s: StallCount got %0d required %0d", name, StallCount, exp);
   endtask

   task automatic drive(input vec_t v);
      IDRs = v.rs; IDRt = v.rt; IDUsesRt = v.uses_rt; IDBranch = v.br;
      IDBranchTaken = v.taken; EXMemRead = v.ex_mr; EXRegWrite = v.ex_rw;
      EXWriteReg = v.ex_wr; MEMMemRead = v.mem_mr; MEMWriteReg = v.mem_wr;
      EXMulStart = v.mul;
   endtask

   function automatic vec_t idle();
      vec_t v;
      v = '{rs:5'd0, rt:5'd0, uses_rt:1'b0, br:1'b0, taken:1'b0, ex_mr:1'b0,
            ex_rw:1'b0, ex_wr:5'd0, mem_mr:1'b0, mem_wr:5'd0, mul:1'b0, exp:O_NONE};
      return v;
   endfunction

   // Reference: outputs derived directly from the hazard rules plus a wait countdown.
   function automatic logic [4:0] ref_out();
      bit lu, bd;
      lu = EXMemRead && EXWriteReg != 0 &&
           (EXWriteReg == IDRs || (IDUsesRt && EXWriteReg == IDRt));
      bd = IDBranch &&
           ((EXRegWrite && EXWriteReg != 0 && (EXWriteReg == IDRs || EXWriteReg == IDRt)) ||
            (MEMMemRead && MEMWriteReg != 0 && (MEMWriteReg == IDRs || MEMWriteReg == IDRt)));
      if (rem > 0 || EXMulStart) return O_MUL;
      if (lu || bd) return O_BUB;
      return {3'b000, IDBranch && IDBranchTaken, 1'b0};
   endfunction

   // Check at negedge, then advance the model across the posedge.
   task automatic cycle(input string name, input logic [4:0] exp);
      @(negedge Clk);
      check_outs(name, exp);
      check_cnt({name, "_cnt"}, exp_cnt);
      @(posedge Clk);
      if (rem > 0) rem--;
      else if (EXMulStart) rem = LAT - 2;
`ifdef HAZARD_STALL_CNT_EN
      if (exp[4]) exp_cnt++;
`endif
      #1;
   endtask

   vec_t tbl[12];
   vec_t v;

   initial begin
      Reset = 1'b0;
      drive(idle());
      #2;
      check_outs("reset_outs", O_NONE);
      check_cnt("reset_cnt", 32'd0);
      v = idle(); v.ex_mr = 1; v.ex_wr = 5'd8; v.rs = 5'd8; v.mul = 1; drive(v);
      #1;
      check_outs("reset_forces_zero", O_NONE);
      drive(idle());
      @(posedge Clk); #2; Reset = 1'b1;
      @(posedge Clk); #1;

      tbl[0]  = idle(); tbl[0].rs = 8; tbl[0].ex_mr = 1; tbl[0].ex_rw = 1; tbl[0].ex_wr = 8; tbl[0].exp = O_BUB;
      tbl[1]  = idle(); tbl[1].rs = 8; tbl[1].ex_wr = 8; tbl[1].exp = O_NONE;
      tbl[2]  = idle(); tbl[2].ex_mr = 1; tbl[2].ex_wr = 0; tbl[2].exp = O_NONE;
      tbl[3]  = idle(); tbl[3].rs = 1; tbl[3].rt = 9; tbl[3].ex_mr = 1; tbl[3].ex_wr = 9; tbl[3].exp = O_NONE;
      tbl[4]  = tbl[3]; tbl[4].uses_rt = 1; tbl[4].exp = O_BUB;
      tbl[5]  = idle(); tbl[5].br = 1; tbl[5].taken = 1; tbl[5].ex_rw = 1; tbl[5].ex_wr = 5; tbl[5].rs = 2; tbl[5].rt = 5; tbl[5].exp = O_BUB;
      tbl[6]  = idle(); tbl[6].br = 1; tbl[6].taken = 1; tbl[6].rs = 2; tbl[6].rt = 5; tbl[6].exp = O_FL;
      tbl[7]  = idle(); tbl[7].br = 1; tbl[7].exp = O_NONE;
      tbl[8]  = idle(); tbl[8].br = 1; tbl[8].taken = 1; tbl[8].mem_mr = 1; tbl[8].mem_wr = 3; tbl[8].rs = 3; tbl[8].exp = O_BUB;
      tbl[9]  = tbl[8]; tbl[9].br = 0; tbl[9].exp = O_NONE;
      tbl[10] = idle(); tbl[10].br = 1; tbl[10].taken = 1; tbl[10].ex_rw = 1; tbl[10].ex_wr = 0; tbl[10].exp = O_FL;
      tbl[11] = idle(); tbl[11].taken = 1; tbl[11].exp = O_NONE;

      for (int i = 0; i < 12; i++) begin
         drive(tbl[i]);
         cycle($sformatf("vec%0d", i), tbl[i].exp);
      end

      // Multiply: LAT-1 hold cycles; restart and load-use during the wait are ignored.
      v = idle(); v.mul = 1; drive(v); cycle("mul_c0", O_MUL);
      v.ex_mr = 1; v.ex_wr = 4; v.rs = 4; drive(v); cycle("mul_c1", O_MUL);
      drive(idle()); cycle("mul_c2", O_MUL);
      cycle("mul_done", O_NONE);

      // Multiply together with a load-use: multiply wins, hazard seen after the wait.
      v = idle(); v.mul = 1; v.ex_mr = 1; v.ex_wr = 6; v.rs = 6; drive(v); cycle("mul_lu_c0", O_MUL);
      v.mul = 0; drive(v); cycle("mul_lu_c1", O_MUL);
      cycle("mul_lu_c2", O_MUL);
      cycle("mul_lu_after", O_BUB);
      drive(idle()); cycle("mul_lu_clear", O_NONE);

      // Asynchronous reset in the second MUL_WAIT cycle.
      v = idle(); v.mul = 1; drive(v); cycle("rst_c0", O_MUL);
      drive(idle()); cycle("rst_c1", O_MUL);
      #2;
      check_outs("rst_pre", O_MUL);
      Reset = 1'b0; #1;
      check_outs("rst_async", O_NONE);
      check_cnt("rst_async_cnt", 32'd0);
      rem = 0; exp_cnt = '0;
      @(posedge Clk); #2; Reset = 1'b1;
      @(posedge Clk); #1;
      cycle("rst_run", O_NONE);

      // Stall counter: one load-use cycle plus a full multiply hold.
      v = idle(); v.ex_mr = 1; v.ex_wr = 8; v.rs = 8; drive(v); cycle("cnt_lu", O_BUB);
      v = idle(); v.mul = 1; drive(v); cycle("cnt_m0", O_MUL);
      drive(idle()); cycle("cnt_m1", O_MUL);
      cycle("cnt_m2", O_MUL);
      @(negedge Clk);
`ifdef HAZARD_STALL_CNT_EN
      check_cnt("cnt_total", 32'd4);
`else
      check_cnt("cnt_total", 32'd0);
`endif

      // Randomized traffic with small register indices to force collisions.
      for (int n = 0; n < 400; n++) begin
         @(posedge Clk); #1;
         IDRs = 5'($urandom_range(0, 3)); IDRt = 5'($urandom_range(0, 3));
         IDUsesRt = 1'($urandom); IDBranch = 1'($urandom); IDBranchTaken = 1'($urandom);
         EXMemRead = 1'($urandom); EXRegWrite = 1'($urandom);
         EXWriteReg = 5'($urandom_range(0, 3)); MEMMemRead = 1'($urandom);
         MEMWriteReg = 5'($urandom_range(0, 3)); EXMulStart = ($urandom_range(0, 7) == 0);
         @(negedge Clk);
         check_outs($sformatf("rand%0d", n), ref_out());
         check_cnt($sformatf("rand%0d_cnt", n), exp_cnt);
         if (rem > 0) rem--;
         else if (EXMulStart) rem = LAT - 2;
`ifdef HAZARD_STALL_CNT_EN
         if (ref_out() & 5'b10000) exp_cnt++;
`endif
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline hazard controller for the 5-stage MIPS datapath; drives the program counter's PCWrite hold input (1 = hold PC) and the IF/ID, ID/EX, EX control inputs.
- Detects load-use hazards, ID-stage branch operand hazards and multi-cycle multiply occupancy.
- Generates holds, bubbles and branch flushes. Timing is set by a small FSM and a multiply countdown.

Parameters:
- MUL_LATENCY, 4, total EX cycles of a multiply (legal range >= 3).
- REG_W, 5, register index width.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- IDRs  in  REG_W  rs of instruction in ID.
- IDRt  in  REG_W  rt of instruction in ID.
- IDUsesRt  in  1  ID instruction reads rt.
- IDBranch  in  1  ID instruction is a branch compared in ID.
- IDBranchTaken  in  1  ID branch comparator result.
- EXMemRead  in  1  EX instruction is a load.
- EXRegWrite  in  1  EX instruction writes a register.
- EXWriteReg  in  REG_W  EX destination register.
- MEMMemRead  in  1  MEM instruction is a load.
- MEMWriteReg  in  REG_W  MEM destination register.
- EXMulStart  in  1  EX instruction is a multiply.
- PCWrite  out  1  1 = hold PC.
- IFIDWrite  out  1  1 = hold IF/ID register.
- IDEXFlush  out  1  1 = load a bubble into ID/EX.
- IFIDFlush  out  1  1 = squash the IF/ID contents (taken branch).
- EXHold  out  1  1 = hold ID/EX and EX/MEM for multiply.
- StallCount  out  32  stall-cycle counter (see Optional Feature).

Behaviour:
- Reset low, asynchronous: state RUN, mul counter 0, StallCount 0. All outputs are forced 0 while Reset is low.
- States:
  - RUN: normal hazard checks.
  - MUL_WAIT: multiply occupying EX.
- LoadUse = EXMemRead & EXWriteReg!=0 & (EXWriteReg==IDRs | (IDUsesRt & EXWriteReg==IDRt)).
- BrDep = IDBranch & ((EXRegWrite & EXWriteReg!=0 & (EXWriteReg==IDRs | EXWriteReg==IDRt)) | (MEMMemRead & MEMWriteReg!=0 & (MEMWriteReg==IDRs | MEMWriteReg==IDRt))).
- The hazard test is combinational, so the hold is visible in the same cycle and the PC holds at the next edge.
- RUN, LoadUse|BrDep: PCWrite=1, IFIDWrite=1, IDEXFlush=1, IFIDFlush=0, EXHold=0.
- RUN, EXMulStart, no LoadUse/BrDep: PCWrite=IFIDWrite=EXHold=1, IDEXFlush=0.
  - Next state MUL_WAIT; counter <= MUL_LATENCY-2.
- EXMulStart together with LoadUse or BrDep: the multiply wins. EXHold=1, IDEXFlush=0, FSM enters MUL_WAIT. The ID hazard is re-evaluated after the wait.
- MUL_WAIT: PCWrite=IFIDWrite=EXHold=1, IDEXFlush=0, IFIDFlush=0. LoadUse, BrDep and EXMulStart are ignored.
  - Each cycle the counter decrements.
  - When the counter==1 at the edge, go to RUN, counter <= 0.
  - Total hold = MUL_LATENCY-1 consecutive cycles.
- RUN, no hazard, no multiply: PCWrite=IFIDWrite=IDEXFlush=EXHold=0. IFIDFlush=IDBranch & IDBranchTaken.
- IFIDFlush is never asserted in a cycle with any hold, because the branch operands are stale.
- Register 0 never creates a hazard.
- Reset asserted mid-MUL_WAIT: return immediately to RUN with all outputs 0.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined: StallCount increments by 1 on each posedge where PCWrite==1 and Reset is high. It wraps at 2^32 and resets to 0.
- Undefined: StallCount is tied to 0 and no counter flops are built. The port list is unchanged.

Decomposition:
- Shared package hazard_pkg holds:
  - the state enum (RUN, MUL_WAIT);
  - the REG_W default;
  - the ZERO_REG constant;
  - a MUL_LATENCY minimum-check constant.
- One natural sub-module: mul_stall_timer, holding the countdown load/decrement and the busy/last-cycle flags.

Test Plan:
- Load-use on rs: EXMemRead=1, EXWriteReg=8, IDRs=8 -> PCWrite=IFIDWrite=IDEXFlush=1 for exactly 1 cycle. The next cycle, with EXMemRead=0, all are 0.
- No hazard on $0, or when rt is unused: EXMemRead=1, EXWriteReg=0, IDRs=0 -> no hold. EXWriteReg=9, IDRt=9, IDUsesRt=0 -> no hold.
- Branch dependence: IDBranch=1, IDBranchTaken=1, EXRegWrite=1, EXWriteReg=5, IDRt=5 -> hold + IDEXFlush=1, IFIDFlush=0. The hazard then clears with IDBranchTaken=1 -> IFIDFlush=1 for 1 cycle.
- Multiply with MUL_LATENCY=4: EXMulStart pulse -> EXHold=PCWrite=1 for exactly 3 cycles, IDEXFlush=0 throughout. The FSM returns to RUN; a second EXMulStart during the wait is ignored.
- Async reset mid-multiply: drop Reset in cycle 2 of MUL_WAIT, off-edge -> all outputs 0 at once. After release the FSM is in RUN.
- With HAZARD_STALL_CNT_EN: one load-use stall plus one MUL_LATENCY=4 stall -> StallCount=4. Without the macro -> StallCount=0.
